// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank (DIR/IN/OUT, atomic SET/CLR/TGL) in a 64-byte window, registered read data.
// Define GPIO_BANK_IRQ_EN to build per-pin rise/fall edge interrupts (RISE_EN, FALL_EN, W1C STATUS, irq).
module gpio_bank #(
  parameter int unsigned WIDTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h20000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      addr,
  input  logic [31:0]      data_i,
  input  logic [3:0]       we,
  output logic [31:0]      data_o,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_en,
  output logic             irq
);

  localparam logic [3:0] OFF_DIR = 4'h0;
  localparam logic [3:0] OFF_IN  = 4'h1;
  localparam logic [3:0] OFF_OUT = 4'h2;
  localparam logic [3:0] OFF_SET = 4'h3;
  localparam logic [3:0] OFF_CLR = 4'h4;
  localparam logic [3:0] OFF_TGL = 4'h5;
`ifdef GPIO_BANK_IRQ_EN
  localparam logic [3:0] OFF_RISE = 4'h6;
  localparam logic [3:0] OFF_FALL = 4'h7;
  localparam logic [3:0] OFF_STAT = 4'h8;
`endif

  logic             hit;
  logic [3:0]       off;
  logic [31:0]      wmask;
  logic [WIDTH-1:0] wmask_w;
  logic [WIDTH-1:0] wbits;

  assign hit     = (addr[31:6] == BASE_ADDR[31:6]);
  assign off     = addr[5:2];
  assign wmask   = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  assign wmask_w = wmask[WIDTH-1:0];
  // Disabled byte lanes contribute zeros, so SET/CLR/TGL/W1C leave those bits alone.
  assign wbits   = data_i[WIDTH-1:0] & wmask_w;

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], data_i, wmask};

  // Input synchroniser; the last stage is the architectural IN value.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync_s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], gpio_in};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] out_q, out_d;

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    if (hit) begin
      case (off)
        OFF_DIR: dir_d = (dir_q & ~wmask_w) | wbits;
        OFF_OUT: out_d = (out_q & ~wmask_w) | wbits;
        OFF_SET: out_d = out_q | wbits;
        OFF_CLR: out_d = out_q & ~wbits;
        OFF_TGL: out_d = out_q ^ wbits;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dir_q <= '0;
      out_q <= '0;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
    end
  end

  assign gpio_out = out_q;
  assign gpio_en  = dir_q;

`ifdef GPIO_BANK_IRQ_EN
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] w1c;

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (hit) begin
      case (off)
        OFF_RISE: rise_en_d = (rise_en_q & ~wmask_w) | wbits;
        OFF_FALL: fall_en_d = (fall_en_q & ~wmask_w) | wbits;
        OFF_STAT: w1c       = wbits;
        default: ;
      endcase
    end
    prev_d   = sync_s;
    // New edges are OR-ed in after the clear so a coincident set survives.
    status_d = (status_q & ~w1c)
             | (sync_s & ~prev_q & rise_en_q)
             | (~sync_s & prev_q & fall_en_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= prev_d;
    end
  end

  assign irq = |status_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux uses pre-write register values; write-only offsets read 0.
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = '0;
    if (hit) begin
      case (off)
        OFF_DIR:  rdata_d[WIDTH-1:0] = dir_q;
        OFF_IN:   rdata_d[WIDTH-1:0] = sync_s;
        OFF_OUT:  rdata_d[WIDTH-1:0] = out_q;
`ifdef GPIO_BANK_IRQ_EN
        OFF_RISE: rdata_d[WIDTH-1:0] = rise_en_q;
        OFF_FALL: rdata_d[WIDTH-1:0] = fall_en_q;
        OFF_STAT: rdata_d[WIDTH-1:0] = status_q;
`endif
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign data_o = rdata_q;

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised memory-mapped GPIO peripheral on the CPU data bus, the next generation of the fixed 16-bit GPIO registers in the top-level SoC. Provides direction and output registers plus atomic set/clear/toggle, a synchronised input register, and per-pin rising/falling edge interrupts with sticky write-1-to-clear status. It decodes its own 64-byte window at `BASE_ADDR` and returns registered read data, one cycle after the address.

## Interface
- `WIDTH`, 16: number of pins, 1..32; register bits above `WIDTH-1` read 0 and ignore writes.
- `BASE_ADDR`, 32'h20000: window base; must be 64-byte aligned.
- `SYNC_STAGES`, 2: input synchroniser depth, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `addr`  in  32  CPU byte address.
- `data_i`  in  32  CPU write data.
- `we`  in  4  CPU byte write enables; 4'h0 = read/idle.
- `data_o`  out  32  registered read data.
- `gpio_in`  in  WIDTH  asynchronous pin inputs.
- `gpio_out`  out  WIDTH  output register.
- `gpio_en`  out  WIDTH  direction register, 1 = drive.
- `irq`  out  1  OR of all STATUS bits.

## Operation
- Hit when `addr[31:6] == BASE_ADDR[31:6]`; offset = `addr[5:2]`; `addr[1:0]` ignored.
- Register map (offset):
  - 0x00 DIR (RW)
  - 0x04 IN (R)
  - 0x08 OUT (RW)
  - 0x0C SET (W, reads 0): OUT |= wdata
  - 0x10 CLR (W, reads 0): OUT &= ~wdata
  - 0x14 TGL (W, reads 0): OUT ^= wdata
  - 0x18 RISE_EN (RW)
  - 0x1C FALL_EN (RW)
  - 0x20 STATUS (R/W1C)
- Writes honour byte enables: byte k of wdata participates only if `we[k]`; for SET/CLR/TGL/W1C a disabled byte acts as wdata byte = 0.
- Unmapped offsets and non-hit addresses: writes ignored, read 0.
- Synchroniser: `SYNC_STAGES` flops on `gpio_in`; output `s` is the IN register value. One further flop `p` holds the previous `s`.
- Edge detect: rise = `s & ~p & RISE_EN`; fall = `~s & p & FALL_EN`; STATUS |= rise | fall each clock.
- W1C: STATUS bits written with 1 clear, except when the same bit sets in the same cycle: set wins.
- Clearing an enable does not clear pending STATUS.
- `irq` = |STATUS, derived only from flops (no glitches from bus inputs).

## Timing
- Reset (async assert, sync use on release): DIR, OUT, RISE_EN, FALL_EN, STATUS, synchroniser, `p`, `data_o` = 0; hence `gpio_out`=0, `gpio_en`=0, `irq`=0.
- Write: register updates on the edge where `addr`/`we` are presented; `gpio_out`/`gpio_en` change at that edge.
- Read: `data_o` loads on every edge with the addressed register (0 if unmapped/miss); valid the cycle after the address. It reflects the pre-write value when read and write coincide.
- Input: pin change sampled at edge N appears in IN at edge N+SYNC_STAGES-1; STATUS bit sets at the next edge; `irq` high in the same cycle.
- Edges while enable is 0 are lost, not queued. Pulses shorter than one clock may be missed.
- Reset mid-operation: all state clears immediately; pending STATUS is lost.

## Configuration
- `GPIO_BANK_IRQ_EN`: defined → RISE_EN, FALL_EN, STATUS, `p` and `irq` logic present as above.
- Not defined → offsets 0x18–0x20 unmapped (read 0, writes ignored), `irq` tied 0, no edge flops; DIR/IN/OUT/SET/CLR/TGL unchanged.

## Test plan
- Reset with `gpio_in`=16'hFFFF → `gpio_out`=0, `gpio_en`=0, `irq`=0, `data_o`=0; read IN after 3 cycles → 16'hFFFF.
- Write OUT=16'h00F0, SET 16'h0003, CLR 16'h0010, TGL 16'h8001 → `gpio_out`=16'h80E2; read SET → 0.
- Write OUT=16'h1234 with `we`=4'b0001 from OUT=0 → `gpio_out`=16'h0034; read at 0x3C → 0, and a write there leaves all registers unchanged.
- RISE_EN=16'h0001, drive pin0 0→1 → STATUS=16'h0001 and `irq`=1 at edge SYNC_STAGES after the sample; falling edge on pin0 → no change; write STATUS 16'h0001 → `irq`=0.
- FALL_EN=16'h0004, pin2 1→0 timed so the fall detect coincides with W1C 16'h0004 → STATUS bit 2 stays 1.
- Build without `GPIO_BANK_IRQ_EN`: write 16'hFFFF to 0x18, toggle all pins → read 0x18 = 0, `irq` stays 0.
